mmio_dispatch: RTL and testbench
================================

# mmio_dispatch

Sequencer and router between the PSL MMIO slave interface (ha_mm*/ah_mm*) and up to NUM_TGT AFU register targets, such as trace arrays, option registers and the AFU descriptor. It captures one MMIO request and decodes the target from the address. It then issues a single-cycle request to that target and waits for its acknowledge, with an optional watchdog. Finally it returns one registered ah_mmack with odd/even parity-correct read data. It sits directly behind the PSL pins and is the only driver of ah_mmack, ah_mmdata and ah_mmdatapar.

## Interface
- NUM_TGT, 4: number of targets; power of two, 2..8.
- TIMEOUT, 255: watchdog cycles in WAIT; 8-bit, must be nonzero.
- ha_pclock  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw  in  1 each  PSL request strobe and qualifiers.
- ha_mmad  in  [0:23]  word address.
- ha_mmdata  in  [0:63]  write data.
- odd_parity  in  1  parity sense for ah_mmdatapar.
- ah_mmack  out  1  single-cycle completion pulse.
- ah_mmdata  out  [0:63]  read data; 0 on writes.
- ah_mmdatapar  out  1  parity of ah_mmdata.
- tgt_req  out  [0:NUM_TGT-1]  one-hot, single-cycle request.
- tgt_cfg, tgt_rnw, tgt_dw  out  1 each  held copies of request qualifiers.
- tgt_ad  out  [0:23]  held address.
- tgt_wdata  out  [0:63]  held write data.
- tgt_ack  in  [0:NUM_TGT-1]  single-cycle completion from targets.
- tgt_rdata  in  [0:64*NUM_TGT-1]  per-target read data, valid with its tgt_ack.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.
- overrun_err  out  1  sticky; a request arrived while busy.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on ha_mmval, latch cfg, rnw, dw, ad and wdata, then go to ISSUE.
- Target select: 0 if ha_mmcfg; otherwise ha_mmad[0:log2(NUM_TGT)-1].
- ISSUE: pulse tgt_req[sel] for one cycle, load the watchdog with TIMEOUT, then go to WAIT.
- WAIT: wait for tgt_ack[sel] and ignore acks from other targets.
  - On ack, capture tgt_rdata[64*sel +: 64] and go to RESP.
  - Each cycle without an ack, decrement the watchdog.
  - When the count reaches 0, capture 64'hFFFF_FFFF_FFFF_FFFF, pulse timeout_err, and go to RESP.
  - If an ack and expiry occur in the same cycle, the ack wins and there is no timeout_err.
- Word-mode (dw=0) reads:
  - ad[23]=1 returns {rdata[32:63], rdata[32:63]}.
  - ad[23]=0 returns {rdata[0:31], rdata[0:31]}.
- Writes return data 0.
- RESP: drive ah_mmack=1 with data and parity for one cycle, then go to IDLE.
- ha_mmval outside IDLE is dropped and sets overrun_err, which clears only on reset.
- Reset mid-operation: the FSM returns to IDLE, any in-flight request is abandoned, and no ack is issued.

## Timing
- Reset values: ah_mmack=0, ah_mmdata=0, ah_mmdatapar=odd_parity, tgt_req=0, timeout_err=0, overrun_err=0, tgt_ad/tgt_wdata=0.
- ha_mmval sampled at edge T: tgt_req is high during T+1. The earliest tgt_ack is sampled at edge T+2, and ah_mmack is high during T+3. Minimum latency is 3 cycles.
- Ack at WAIT edge E: ah_mmack is high during E+1.
- Timeout path: ah_mmack follows TIMEOUT+1 cycles after the end of tgt_req.
- ah_mmdatapar is computed combinationally from the registered data, so it is valid in the same cycle as ah_mmack.
- A new ha_mmval is accepted in the cycle after ah_mmack (IDLE).

## Configuration
- MMIO_DISPATCH_TIMEOUT_EN defined: the watchdog is present as described, and timeout_err is live.
- MMIO_DISPATCH_TIMEOUT_EN undefined:
  - No counter; WAIT holds until tgt_ack.
  - timeout_err is tied to 0.
  - The TIMEOUT parameter is ignored.

## Structure
- Package mmio_pkg:
  - FSM state enum.
  - MMIO_AD_W=24 and MMIO_DATA_W=64.
  - MMIO_TIMEOUT_DATA=64'hFFFF_FFFF_FFFF_FFFF.
  - Word-select helper function.
- Reuse the existing parity module (BITS=64) for ah_mmdatapar.
- One natural sub-module: mmio_tgt_mux, which selects the acked target's rdata and applies word-mode replication.

## Test plan
- MMIO dw read, ad=24'h400010, target 1 acks 2 cycles after req with rdata 64'h0123456789ABCDEF -> tgt_req[1] pulse; ah_mmack 1 cycle after ack with data 0123456789ABCDEF and correct parity for odd_parity=1.
- Word read, cfg=1, ad=24'h000001, target 0 rdata 64'h0000000100010010 -> ah_mmdata=64'h0001001000010010.
- Write, ad=24'hC00000, data 64'hDEAD -> tgt_req[3], tgt_wdata=64'hDEAD; ah_mmack with ah_mmdata=0.
- No ack (TIMEOUT_EN, TIMEOUT=4) -> timeout_err pulse and ah_mmack with all-ones data 5 cycles after tgt_req.
- Second ha_mmval during WAIT -> dropped, overrun_err=1; first request completes normally. With the ack and expiry coincident -> normal data, no timeout_err.
- reset_n low during WAIT -> all outputs reach reset values immediately; a later target ack is ignored; no ah_mmack.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the MMIO dispatcher.
//   - mmio_state_e       : dispatcher FSM states
//   - MMIO_AD_W / MMIO_DATA_W : PSL MMIO address and data widths
//   - MMIO_TIMEOUT_DATA  : read data returned when a target never answers
//   - mmio_word_sel()    : shapes a 64-bit target beat for word/doubleword reads
// Bit vectors use the PSL big-endian numbering: bit 0 is the MSB.
package mmio_pkg;

  localparam int MMIO_AD_W   = 24;
  localparam int MMIO_DATA_W = 64;

  localparam logic [MMIO_DATA_W-1:0] MMIO_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mmio_state_e;

  // Word reads replicate the addressed 32-bit half into both halves of the bus;
  // lo_word is address bit 23 (the odd word is the less significant half).
  function automatic logic [0:MMIO_DATA_W-1] mmio_word_sel(
    input logic [0:MMIO_DATA_W-1] rdata,
    input logic                   dw,
    input logic                   lo_word
  );
    logic [0:MMIO_DATA_W-1] res;
    if (dw) begin
      res = rdata;
    end else if (lo_word) begin
      res = {rdata[32:63], rdata[32:63]};
    end else begin
      res = {rdata[0:31], rdata[0:31]};
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_tgt_mux.sv
// mmio_tgt_mux: read-data path of the MMIO dispatcher.
// Selects the beat of the addressed target (or the timeout pattern when the
// watchdog fired), then applies word-mode replication; writes yield zero.
//   sel       : target index
//   tgt_rdata : concatenated per-target read data, target 0 first
//   rnw, dw   : held request qualifiers
//   lo_word   : held address bit 23
//   timeout   : watchdog expired this cycle
//   data      : shaped response data (combinational)
module mmio_tgt_mux
  import mmio_pkg::*;
#(
  parameter int NUM_TGT = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]           sel,
  input  logic [0:64*NUM_TGT-1]      tgt_rdata,
  input  logic                       rnw,
  input  logic                       dw,
  input  logic                       lo_word,
  input  logic                       timeout,
  output logic [0:MMIO_DATA_W-1]     data
);

  logic [0:MMIO_DATA_W-1] raw_s;

  // Choose the source beat, then shape it for the access type.
  always_comb begin
    raw_s = {MMIO_DATA_W{1'b0}};
    data  = {MMIO_DATA_W{1'b0}};
    if (timeout) begin
      raw_s = MMIO_TIMEOUT_DATA;
    end else begin
      raw_s = tgt_rdata[MMIO_DATA_W*int'(sel) +: MMIO_DATA_W];
    end
    if (rnw) begin
      data = mmio_word_sel(raw_s, dw, lo_word);
    end else begin
      data = {MMIO_DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/parity.sv
// parity: parity generator over BITS data bits.
//   data : vector to protect
//   odd  : 1 = odd parity (data plus par has an odd number of ones), 0 = even
//   par  : parity bit
module parity #(
  parameter int BITS = 64
) (
  input  logic [0:BITS-1] data,
  input  logic            odd,
  output logic            par
);

  // Even parity is the XOR reduction; odd parity inverts it.
  function automatic logic calc_par(input logic [0:BITS-1] d, input logic o);
    return (^d) ^ o;
  endfunction

  assign par = calc_par(data, odd);

endmodule

// File: rtl/mmio_dispatch.sv
// mmio_dispatch: sequences one PSL MMIO request at a time to one of NUM_TGT
// register targets and returns a single registered ah_mmack with parity.
// Configuration macro: MMIO_DISPATCH_TIMEOUT_EN enables the WAIT watchdog
// (TIMEOUT cycles) and timeout_err; without it WAIT holds until tgt_ack.
// Ports:
//   ha_pclock, reset_n            : clock, async active-low reset
//   ha_mm{val,cfg,rnw,dw,ad,data} : PSL MMIO request
//   odd_parity                    : parity sense for ah_mmdatapar
//   ah_mm{ack,data,datapar}       : registered response
//   tgt_req/cfg/rnw/dw/ad/wdata   : one-hot request and held request fields
//   tgt_ack, tgt_rdata            : per-target completion and read data
//   timeout_err, overrun_err      : watchdog pulse, sticky busy-drop flag
module mmio_dispatch
  import mmio_pkg::*;
#(
  parameter int NUM_TGT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     ha_pclock,
  input  logic                     reset_n,
  input  logic                     ha_mmval,
  input  logic                     ha_mmcfg,
  input  logic                     ha_mmrnw,
  input  logic                     ha_mmdw,
  input  logic [0:MMIO_AD_W-1]     ha_mmad,
  input  logic [0:MMIO_DATA_W-1]   ha_mmdata,
  input  logic                     odd_parity,
  output logic                     ah_mmack,
  output logic [0:MMIO_DATA_W-1]   ah_mmdata,
  output logic                     ah_mmdatapar,
  output logic [0:NUM_TGT-1]       tgt_req,
  output logic                     tgt_cfg,
  output logic                     tgt_rnw,
  output logic                     tgt_dw,
  output logic [0:MMIO_AD_W-1]     tgt_ad,
  output logic [0:MMIO_DATA_W-1]   tgt_wdata,
  input  logic [0:NUM_TGT-1]       tgt_ack,
  input  logic [0:64*NUM_TGT-1]    tgt_rdata,
  output logic                     timeout_err,
  output logic                     overrun_err
);

  localparam int SEL_W = $clog2(NUM_TGT);

  mmio_state_e              state_r, state_nxt_s;
  logic [SEL_W-1:0]         sel_in_s, sel_r;
  logic                     latch_s, capture_s, expire_s, ack_hit_s, wd_expired_s;
  logic [0:NUM_TGT-1]       req_nxt_s, req_r;
  logic                     cfg_r, rnw_r, dw_r;
  logic [0:MMIO_AD_W-1]     ad_r;
  logic [0:MMIO_DATA_W-1]   wdata_r, mux_data_s, data_r;
  logic                     ack_r, tmo_err_r, ovr_r;

  // Config-space accesses always go to target 0; others decode the top address bits.
  assign sel_in_s  = ha_mmcfg ? {SEL_W{1'b0}} : ha_mmad[0:SEL_W-1];
  assign ack_hit_s = tgt_ack[sel_r];

`ifdef MMIO_DISPATCH_TIMEOUT_EN
  logic [7:0] wd_cnt_r;

  // Watchdog: reloaded during ISSUE, decremented every WAIT cycle.
  always_ff @(posedge ha_pclock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_r <= 8'd0;
    end else if (state_r == ST_ISSUE) begin
      wd_cnt_r <= 8'(TIMEOUT);
    end else if (state_r == ST_WAIT) begin
      wd_cnt_r <= wd_cnt_r - 8'd1;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // A count of 1 means this WAIT cycle is the last one before reaching zero.
  assign wd_expired_s = (state_r == ST_WAIT) && (wd_cnt_r == 8'd1);
`else
  assign wd_expired_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge ha_pclock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and control strobes; an ack beats a coincident watchdog expiry.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    capture_s   = 1'b0;
    expire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ha_mmval) begin
          latch_s     = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (ack_hit_s) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (wd_expired_s) begin
          capture_s   = 1'b1;
          expire_s    = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One-hot request for the decoded target, raised for the ISSUE cycle only.
  always_comb begin
    req_nxt_s = {NUM_TGT{1'b0}};
    if (latch_s) begin
      req_nxt_s[sel_in_s] = 1'b1;
    end else begin
      req_nxt_s = {NUM_TGT{1'b0}};
    end
  end

  // Hold the accepted request fields for the targets until the next request.
  always_ff @(posedge ha_pclock or negedge reset_n) begin
    if (!reset_n) begin
      sel_r   <= {SEL_W{1'b0}};
      cfg_r   <= 1'b0;
      rnw_r   <= 1'b0;
      dw_r    <= 1'b0;
      ad_r    <= {MMIO_AD_W{1'b0}};
      wdata_r <= {MMIO_DATA_W{1'b0}};
    end else if (latch_s) begin
      sel_r   <= sel_in_s;
      cfg_r   <= ha_mmcfg;
      rnw_r   <= ha_mmrnw;
      dw_r    <= ha_mmdw;
      ad_r    <= ha_mmad;
      wdata_r <= ha_mmdata;
    end else begin
      sel_r   <= sel_r;
      cfg_r   <= cfg_r;
      rnw_r   <= rnw_r;
      dw_r    <= dw_r;
      ad_r    <= ad_r;
      wdata_r <= wdata_r;
    end
  end

  mmio_tgt_mux #(
    .NUM_TGT (NUM_TGT),
    .SEL_W   (SEL_W)
  ) u_tgt_mux (
    .sel       (sel_r),
    .tgt_rdata (tgt_rdata),
    .rnw       (rnw_r),
    .dw        (dw_r),
    .lo_word   (ad_r[MMIO_AD_W-1]),
    .timeout   (expire_s),
    .data      (mux_data_s)
  );

  // Response, request pulse and error registers; data is zero outside the ack cycle.
  always_ff @(posedge ha_pclock or negedge reset_n) begin
    if (!reset_n) begin
      req_r     <= {NUM_TGT{1'b0}};
      ack_r     <= 1'b0;
      data_r    <= {MMIO_DATA_W{1'b0}};
      tmo_err_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      req_r     <= req_nxt_s;
      ack_r     <= capture_s;
      data_r    <= capture_s ? mux_data_s : {MMIO_DATA_W{1'b0}};
      tmo_err_r <= expire_s;
      ovr_r     <= ovr_r | (ha_mmval && (state_r != ST_IDLE));
    end
  end

  parity #(
    .BITS (MMIO_DATA_W)
  ) u_parity (
    .data (data_r),
    .odd  (odd_parity),
    .par  (ah_mmdatapar)
  );

  assign ah_mmack    = ack_r;
  assign ah_mmdata   = data_r;
  assign tgt_req     = req_r;
  assign tgt_cfg     = cfg_r;
  assign tgt_rnw     = rnw_r;
  assign tgt_dw      = dw_r;
  assign tgt_ad      = ad_r;
  assign tgt_wdata   = wdata_r;
  assign timeout_err = tmo_err_r;
  assign overrun_err = ovr_r;

endmodule

// File: tb/tb_mmio_dispatch.sv
// tb_mmio_dispatch: randomized self-checking bench for mmio_dispatch.
// A transaction-level reference model predicts, per request, the selected
// target, response cycle, data, parity, timeout and overrun status.
`timescale 1ns/1ps
module tb_mmio_dispatch;

  localparam int NT  = 4;
  localparam int TMO = 4;
`ifdef MMIO_DISPATCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            ha_pclock = 1'b0;
  logic            reset_n   = 1'b0;
  logic            ha_mmval  = 1'b0;
  logic            ha_mmcfg  = 1'b0;
  logic            ha_mmrnw  = 1'b0;
  logic            ha_mmdw   = 1'b0;
  logic [0:23]     ha_mmad   = '0;
  logic [0:63]     ha_mmdata = '0;
  logic            odd_parity = 1'b1;
  logic            ah_mmack, ah_mmdatapar;
  logic [0:63]     ah_mmdata;
  logic [0:NT-1]   tgt_req;
  logic            tgt_cfg, tgt_rnw, tgt_dw;
  logic [0:23]     tgt_ad;
  logic [0:63]     tgt_wdata;
  logic [0:NT-1]   tgt_ack   = '0;
  logic [0:64*NT-1] tgt_rdata = '0;
  logic            timeout_err, overrun_err;

  int  checks   = 0;
  int  failures = 0;
  bit  ovr_model = 1'b0;

  mmio_dispatch #(.NUM_TGT(NT), .TIMEOUT(TMO)) dut (
    .ha_pclock(ha_pclock), .reset_n(reset_n),
    .ha_mmval(ha_mmval), .ha_mmcfg(ha_mmcfg), .ha_mmrnw(ha_mmrnw), .ha_mmdw(ha_mmdw),
    .ha_mmad(ha_mmad), .ha_mmdata(ha_mmdata), .odd_parity(odd_parity),
    .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata), .ah_mmdatapar(ah_mmdatapar),
    .tgt_req(tgt_req), .tgt_cfg(tgt_cfg), .tgt_rnw(tgt_rnw), .tgt_dw(tgt_dw),
    .tgt_ad(tgt_ad), .tgt_wdata(tgt_wdata), .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 ha_pclock = ~ha_pclock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference response data: writes 0, timeouts all-ones, word reads replicate a half.
  function automatic logic [63:0] model_data(input bit rnw, input bit dw, input logic [23:0] ad,
                                             input logic [63:0] rd, input bit tmo);
    logic [63:0] v;
    if (!rnw) return 64'd0;
    v = tmo ? 64'hFFFF_FFFF_FFFF_FFFF : rd;
    if (dw) return v;
    return ad[0] ? {v[31:0], v[31:0]} : {v[63:32], v[63:32]};
  endfunction

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ack"},  ah_mmack, 0);
    check_val({tag, "_data"}, ah_mmdata, 0);
    check_val({tag, "_par"},  ah_mmdatapar, odd_parity);
    check_val({tag, "_req"},  tgt_req, 0);
    check_val({tag, "_tmo"},  timeout_err, 0);
    check_val({tag, "_ovr"},  overrun_err, 0);
    check_val({tag, "_ad"},   tgt_ad, 0);
    check_val({tag, "_wd"},   tgt_wdata, 0);
  endtask

  // One MMIO transaction. d: target acks during the (d+1)th cycle after tgt_req.
  task automatic run_txn(input string tag, input bit cfg, input bit rnw, input bit dw,
                         input logic [23:0] ad, input logic [63:0] wd, input int d,
                         input bit ovr_poke, input bit odd, input bit use_rd,
                         input logic [63:0] rd_val);
    int t, exp_j, got_j, stray_req, stray_tmo;
    bit tmo;
    logic [63:0] rd [NT];
    logic [63:0] exp_d, got_d;
    logic got_par, got_tmo;
    logic [0:NT-1] oh;

    t     = cfg ? 0 : int'(ad >> 22);
    tmo   = TMO_EN && (d >= TMO);
    exp_j = tmo ? TMO + 1 : d + 2;
    for (int i = 0; i < NT; i++) begin
      rd[i] = {$urandom, $urandom};
      tgt_rdata[64*i +: 64] = rd[i];
    end
    if (use_rd) begin
      rd[t] = rd_val;
      tgt_rdata[64*t +: 64] = rd_val;
    end
    exp_d = model_data(rnw, dw, ad, rd[t], tmo);

    odd_parity = odd;
    ha_mmval = 1'b1; ha_mmcfg = cfg; ha_mmrnw = rnw; ha_mmdw = dw;
    ha_mmad = ad; ha_mmdata = wd;
    @(negedge ha_pclock);
    ha_mmval = 1'b0;
    ha_mmad = 24'($urandom);
    ha_mmdata = {$urandom, $urandom};
    tgt_ack = '0;

    oh = '0;
    oh[t] = 1'b1;
    check_val({tag, "_req"}, tgt_req, oh);
    check_val({tag, "_tad"}, tgt_ad, ad);
    check_val({tag, "_twd"}, tgt_wdata, wd);
    check_val({tag, "_tq"},  {tgt_cfg, tgt_rnw, tgt_dw}, {cfg, rnw, dw});

    got_j = -1; got_d = 'x; got_par = 1'bx; got_tmo = 1'bx;
    stray_req = 0; stray_tmo = 0;
    for (int j = 1; j <= 40 && got_j < 0; j++) begin
      @(negedge ha_pclock);
      if (ah_mmack === 1'b1) begin
        got_j = j; got_d = ah_mmdata; got_par = ah_mmdatapar; got_tmo = timeout_err;
      end else begin
        if (tgt_req !== '0) stray_req++;
        if (timeout_err !== 1'b0) stray_tmo++;
        tgt_ack = '0;
        if (j == d + 1) tgt_ack[t] = 1'b1;
        else if ($urandom_range(0, 2) == 0) tgt_ack[(t + 1 + $urandom_range(0, NT - 2)) % NT] = 1'b1;
        ha_mmval = ovr_poke && (j == 1);
      end
    end
    tgt_ack = '0;
    ha_mmval = 1'b0;
    if (ovr_poke) ovr_model = 1'b1;

    check_val({tag, "_lat"},   got_j, exp_j);
    check_val({tag, "_data"},  got_d, exp_d);
    check_val({tag, "_par"},   got_par, (^exp_d) ^ odd);
    check_val({tag, "_tmo"},   got_tmo, tmo);
    check_val({tag, "_sreq"},  stray_req, 0);
    check_val({tag, "_stmo"},  stray_tmo, 0);

    @(negedge ha_pclock);
    check_val({tag, "_ack1"},  ah_mmack, 0);
    check_val({tag, "_ovr"},   overrun_err, ovr_model);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int acks;
    repeat (3) @(negedge ha_pclock);
    check_reset_state("rst0");
    reset_n = 1'b1;
    @(negedge ha_pclock);
    check_reset_state("idle0");

    run_txn("dw_rd",  1'b0, 1'b1, 1'b1, 24'h400010, 64'd0, 1, 1'b0, 1'b1, 1'b1, 64'h0123456789ABCDEF);
    run_txn("wd_rd",  1'b1, 1'b1, 1'b0, 24'h000001, 64'd0, 0, 1'b0, 1'b0, 1'b1, 64'h0000000100010010);
    run_txn("wr",     1'b0, 1'b0, 1'b1, 24'hC00000, 64'hDEAD, 2, 1'b0, 1'b1, 1'b0, 64'd0);
    run_txn("noack",  1'b0, 1'b1, 1'b1, 24'h800008, 64'd0, 20, 1'b0, 1'b1, 1'b0, 64'd0);
    run_txn("ovr",    1'b0, 1'b1, 1'b1, 24'h400000, 64'd0, 2, 1'b1, 1'b0, 1'b0, 64'd0);
    run_txn("coinc",  1'b0, 1'b1, 1'b0, 24'hC00002, 64'd0, TMO - 1, 1'b0, 1'b1, 1'b0, 64'd0);

    for (int n = 0; n < 60; n++) begin
      bit rnw;
      rnw = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge ha_pclock);
      run_txn("rnd", ($urandom % 4) == 0, rnw, 1'($urandom), 24'($urandom), {$urandom, $urandom},
              rnw ? $urandom_range(0, 6) : $urandom_range(0, 3), ($urandom % 6) == 0,
              1'($urandom), 1'b0, 64'd0);
    end

    // Reset in WAIT: abandon the request, no late ack.
    odd_parity = 1'($urandom);
    ha_mmval = 1'b1; ha_mmcfg = 1'b0; ha_mmrnw = 1'b1; ha_mmdw = 1'b1;
    ha_mmad = 24'h400004; ha_mmdata = 64'h1234;
    @(negedge ha_pclock);
    ha_mmval = 1'b1;
    @(negedge ha_pclock);
    ha_mmval = 1'b0;
    @(negedge ha_pclock);
    reset_n = 1'b0;
    #1;
    check_reset_state("rst_wait");
    @(negedge ha_pclock);
    reset_n = 1'b1;
    ovr_model = 1'b0;
    tgt_ack = '0;
    tgt_ack[1] = 1'b1;
    acks = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge ha_pclock);
      tgt_ack = '0;
      if (ah_mmack !== 1'b0 || tgt_req !== '0) acks++;
    end
    check_val("rst_noack", acks, 0);
    check_val("rst_ovr", overrun_err, ovr_model);

    run_txn("post_rst", 1'b0, 1'b1, 1'b1, 24'h400010, 64'd0, 1, 1'b0, 1'b0, 1'b1, 64'hA5A5_0000_FFFF_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
